// File: rtl/display_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the multiplexed 7-segment scan controller.
//   scan_state_t : scan FSM encoding (OFF / ON / GUARD)
//   NIBBLE_W     : width of one hex digit
//   anode_vec()  : one-hot anode pattern for a digit, with polarity applied
// ---------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        SCAN_OFF   = 2'd0,
        SCAN_ON    = 2'd1,
        SCAN_GUARD = 2'd2
    } scan_state_t;

    localparam int NIBBLE_W = 4;

    // Returns a 32-bit pattern; callers truncate to their digit count.
    // When 'on' is 0 every anode is inactive.
    function automatic logic [31:0] anode_vec(input int unsigned index,
                                              input logic        on,
                                              input logic        active_low);
        logic [31:0] v;
        v = on ? (32'd1 << index) : 32'd0;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl_if
// Bundles the datapath-side controls and the decoder/anode outputs of the
// scan controller.
//   master : datapath/board side (drives en, load, valor, dp_mask, blank_lz)
//   slave  : scan controller (drives anodos, dado_out, dp_out, frame_done)
// ---------------------------------------------------------------------------
interface display_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] valor;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   anodos;
    logic [3:0]              dado_out;
    logic                    dp_out;
    logic                    frame_done;

    modport master (
        output en, load, valor, dp_mask, blank_lz,
        input  anodos, dado_out, dp_out, frame_done
    );

    modport slave (
        input  en, load, valor, dp_mask, blank_lz,
        output anodos, dado_out, dp_out, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl_lz_mask.sv
// ---------------------------------------------------------------------------
// display_lz_mask
// Combinational leading-zero blank mask. Digit i (i>0) is blanked when
// blank_lz is set, nibbles i..NUM_DIGITS-1 are all zero and its own decimal
// point is off. Digit 0 is never blanked, so only digits 1.. are inputs.
//   nibbles  : shadow nibbles of digits 1..NUM_DIGITS-1 (digit 1 in LSBs)
//   dp       : shadow decimal points of digits 1..NUM_DIGITS-1
//   blank_lz : suppression enable
//   blank    : per-digit blank mask (bit 0 always 0)
// ---------------------------------------------------------------------------
module display_lz_mask
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [NIBBLE_W*(NUM_DIGITS-1)-1:0] nibbles,
    input  logic [NUM_DIGITS-1:1]              dp,
    input  logic                               blank_lz,
    output logic [NUM_DIGITS-1:0]              blank
);
    logic upper_zero;

    // Walk from the most significant digit down; a digit stays blankable
    // only while everything above it (and itself) is zero.
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (nibbles[(i-1)*NIBBLE_W +: NIBBLE_W] == '0);
            blank[i]   = blank_lz && upper_zero && !dp[i];
        end
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits that
// share one 7-segment decoder. Each digit is lit for REFRESH_DIV cycles,
// followed by GUARD_CYCLES of all-off dead time. Display data is double
// buffered so a new value always appears from digit 0 of a fresh frame.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of display_scan_ctrl_if
//              (en, load, valor, dp_mask, blank_lz in;
//               anodos, dado_out, dp_out, frame_done out, all registered)
// ---------------------------------------------------------------------------
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int GUARD_CYCLES     = 2,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_OFF   = SCAN_OFF;
    localparam logic [1:0] ST_ON    = SCAN_ON;
    localparam logic [1:0] ST_GUARD = SCAN_GUARD;

    localparam int CNT_MAX0 = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
    localparam int CW       = $clog2(CNT_MAX);
    localparam int IW       = $clog2(NUM_DIGITS);
    localparam int VW       = NIBBLE_W * NUM_DIGITS;

    localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic          ACT_LOW    = (ANODE_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = NUM_DIGITS'(anode_vec(0, 1'b0, ACT_LOW));

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [VW-1:0]         pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [VW-1:0]         shad_val_q, shad_val_d;
    logic [NUM_DIGITS-1:0] shad_dp_q, shad_dp_d;
    logic [NUM_DIGITS-1:0] anodos_q, anodos_d;
    logic [3:0]            dado_q, dado_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic                  wrap;
    logic [IW-1:0]         idx_inc;
    logic                  idx_last;
    logic [NUM_DIGITS-1:0] blank;

    assign idx_last = (idx_q == IDX_LAST);
    assign idx_inc  = idx_last ? '0 : idx_q + 1'b1;

    // Scan FSM: slot timing and digit index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        if (!bus.en) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_ON;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        cnt_d = '0;
                        if (GUARD_CYCLES > 0) begin
                            state_d = ST_GUARD;
                        end else begin
                            idx_d = idx_inc;
                            wrap  = idx_last;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ON;
                        idx_d   = idx_inc;
                        wrap    = idx_last;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Double buffer: shadow only changes on a frame boundary or while idle,
    // so a frame is never torn. A load coinciding with that edge bypasses
    // the pending stage.
    always_comb begin
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        shad_val_d  = shad_val_q;
        shad_dp_d   = shad_dp_q;
        if (bus.load) begin
            pend_val_d  = bus.valor;
            pend_dp_d   = bus.dp_mask;
            pend_flag_d = 1'b1;
        end
        if (wrap || (state_q == ST_OFF)) begin
            if (bus.load) begin
                shad_val_d  = bus.valor;
                shad_dp_d   = bus.dp_mask;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                shad_val_d  = pend_val_q;
                shad_dp_d   = pend_dp_q;
                pend_flag_d = 1'b0;
            end
        end
    end

    display_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .nibbles  (shad_val_d[VW-1:NIBBLE_W]),
        .dp       (shad_dp_d[NUM_DIGITS-1:1]),
        .blank_lz (bus.blank_lz),
        .blank    (blank)
    );

    // Outputs are derived from next-state values so nibble, dp and anodes
    // all move on the same edge; outside ON the nibble and dp hold.
    always_comb begin
        anodos_d     = ANODES_OFF;
        dado_d       = dado_q;
        dp_d         = dp_q;
        frame_done_d = wrap;
        if (state_d == ST_ON) begin
            anodos_d = NUM_DIGITS'(anode_vec(32'(idx_d), !blank[idx_d], ACT_LOW));
            dado_d   = shad_val_d[32'(idx_d)*NIBBLE_W +: NIBBLE_W];
            dp_d     = shad_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_OFF;
            idx_q        <= '0;
            cnt_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            shad_val_q   <= '0;
            shad_dp_q    <= '0;
            anodos_q     <= ANODES_OFF;
            dado_q       <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            shad_val_q   <= shad_val_d;
            shad_dp_q    <= shad_dp_d;
            anodos_q     <= anodos_d;
            dado_q       <= dado_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.anodos     = anodos_q;
    assign bus.dado_out   = dado_q;
    assign bus.dp_out     = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of NUM_DIGITS common-anode 7-segment digits that share one display7seg decoder. It holds a double-buffered copy of the hex value, selects one digit at a time for REFRESH_DIV cycles and inserts GUARD_CYCLES of all-off dead time between digits to prevent ghosting. It feeds dado_out/dp_out to the decoder and drives the digit anodes. It sits between the datapath result registers and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2)
REFRESH_DIV, 50000, clk cycles each digit is lit (>=1)
GUARD_CYCLES, 2, clk cycles of all-anodes-off between digits (>=0; 0 = no guard state)
ANODE_ACTIVE_LOW, 1, 1: anode on = 0; 0: anode on = 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  1  scan enable
load  input  1  capture valor/dp_mask this cycle
valor  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = least significant)
dp_mask  input  NUM_DIGITS  decimal point per digit
blank_lz  input  1  leading-zero suppression enable (sampled live)
anodos  output  NUM_DIGITS  digit enables, polarity per ANODE_ACTIVE_LOW
dado_out  output  4  nibble to decoder
dp_out  output  1  decimal point to decoder
frame_done  output  1  one-cycle pulse at the end of each full scan

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). All outputs registered.
- Reset values: state OFF; anodos all inactive; dado_out 0; dp_out 0; frame_done 0; digit index 0; counter 0; pending and shadow registers 0; pending flag 0.
- States: OFF, ON, GUARD.
- OFF: anodos inactive. If en=1, the next edge enters ON with index 0 and counter 0.
- ON: anodos activate digit index only, unless that digit is blanked (see below). dado_out = shadow nibble[index]; dp_out = shadow dp[index]. The counter runs 0..REFRESH_DIV-1. At REFRESH_DIV-1, go to GUARD; if GUARD_CYCLES=0, advance the index and stay in ON.
- GUARD: anodos inactive; dado_out and dp_out hold. After GUARD_CYCLES cycles, advance the index and enter ON.
- Index advance: from NUM_DIGITS-1 wrap to 0. The wrap is the frame boundary, and frame_done=1 for exactly the cycle after the wrapping edge.
- dado_out, dp_out and anodos change on the same edge. The decoder never sees a nibble change while an anode is lit.
- en=0 in any state: the next edge enters OFF. Index, counter and frame_done clear; anodos go inactive.
- Frame period (en held): NUM_DIGITS*(REFRESH_DIV+GUARD_CYCLES) cycles.
- load=1: valor/dp_mask are captured into the pending registers and the pending flag is set.
- Pending-to-shadow transfer happens at the frame boundary edge, or at any edge while in OFF. The pending flag clears on transfer.
- If load=1 on the boundary edge, valor/dp_mask go directly into shadow on that edge and the pending flag is cleared. New data always shows from digit 0, with no tearing within a frame.
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz=1, the shadow nibbles i..NUM_DIGITS-1 are all 0, and dp of digit i is 0. Digit 0 is never blanked. A blanked digit keeps its anode inactive for its ON slot, but the slot timing is unchanged.
- Counter width: $clog2(max(REFRESH_DIV, GUARD_CYCLES, 2)). The counter never wraps past its terminal value.
- Reset mid-operation: all outputs go to reset values immediately, with no clock edge required.

Decomposition:
- Shared package display_pkg:
  - scan_state_t enum {OFF, ON, GUARD}
  - NIBBLE_W = 4
  - function anode_vec(index, on, active_low)
- Sub-module display_lz_mask: combinational; inputs shadow nibbles, dp, blank_lz; output NUM_DIGITS blank mask.
- The display7seg decoder is instantiated by the parent, not inside this block.

Test Plan:
(Parameters for all: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, ANODE_ACTIVE_LOW=1.)
1. Release rst, load valor=16'h1234 with en=0, then en=1.
   - Expected: anodos=1110 and dado_out=4 for 4 cycles, then 1111 for 1 cycle.
   - Next: 1101/3, then 1011/2, then 0111/1.
   - frame_done pulses every 20 cycles.
2. Running with 16'h1234; load 16'hABCD while digit 2 is lit.
   - Expected: digits 2 and 3 still show 2 and 1.
   - Next frame shows D, C, B, A.
3. blank_lz=1, valor=16'h0005.
   - Expected: digits 3, 2, 1 keep anodos=1111 in their slots; digit 0 shows 5.
   - With valor=16'h0000: only digit 0 lit, showing 0.
   - With dp_mask=4'b0100: digit 2 is lit, showing 0.
4. en=0 mid-ON of digit 1.
   - Expected: next edge anodos=1111 and state OFF.
   - After en=1: next edge anodos=1110 (digit 0), counter restarted.
5. Assert rst asynchronously mid-ON of digit 2.
   - Expected: anodos=1111, dado_out=0, frame_done=0 before any clk edge.
6. load=1 exactly on the wrap edge with valor=16'h00F0.
   - Expected: digit 0 of the new frame shows 0 and digit 1 shows F, with no frame of stale data.
